// File: rtl/mole_pkg.sv
// Shared definitions for the mole game sequencing blocks.
package mole_pkg;

  // Number of mole units and the width of an index into them.
  localparam int NUM_MOLES = 8;
  localparam int IDX_W     = 3;

  // Galois mask for the 16-bit LFSR, taps 16,14,13,11 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Scheduler state encoding.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_GAP = 3'd1,
    PICK     = 3'd2,
    LAUNCH   = 3'd3,
    DRAIN    = 3'd4,
    DONE     = 3'd5
  } state_t;

  // One Galois step: shift right, fold the tap mask in when a 1 falls out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/mole_lfsr16.sv
// 16-bit Galois LFSR with hold enable; the seed is loaded by reset.
module mole_lfsr16
  import mole_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        enable,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  // Advance one step per enabled cycle, otherwise hold.
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!resetn) begin
      value <= seed;
    end else if (enable) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/mole_scheduler.sv
// Paces and chooses mole launches for one round, capping moles above ground.
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int          MAX_UP       = 3,
  parameter int          ROUND_SPAWNS = 60,
  parameter int          GAP_TICKS    = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 tick,
  input  logic [NUM_MOLES-1:0] hiding,
  output logic [NUM_MOLES-1:0] control,
  output logic                 game_active,
  output logic                 round_done,
  output logic [7:0]           spawn_cnt
);

  // Gap value that makes the very next tick count as reaching GAP_TICKS.
  localparam logic [3:0] GAP_LAST = 4'(GAP_TICKS - 1);

  state_t               state, state_next;
  logic [3:0]           gap_cnt, gap_next;
  logic [IDX_W-1:0]     idx, idx_next;
  logic [IDX_W-1:0]     probe_cnt, probe_next;
  logic [NUM_MOLES-1:0] pending, pending_next;
  logic [NUM_MOLES-1:0] control_next;
  logic [7:0]           spawn_next;

  logic [NUM_MOLES-1:0] occupied;
  logic [NUM_MOLES-1:0] eligible;
  logic [3:0]           up_count;
  logic                 at_cap;
  logic                 gap_reached;
  logic                 lfsr_en;
  logic [15:0]          lfsr_value;
  logic                 unused_lfsr_bits;

  // Random source; runs only while a round is in progress.
  assign lfsr_en = (state != IDLE) && (state != DONE);

  mole_lfsr16 u_lfsr (
    .clock  (CLOCK_50),
    .resetn (resetn),
    .enable (lfsr_en),
    .seed   (LFSR_SEED),
    .value  (lfsr_value)
  );

  // Only the low bits pick a mole; the rest are left for a future height picker.
  assign unused_lfsr_bits = ^lfsr_value[15:IDX_W];

  // A mole is busy if it is out of its hole or was just sent and has not left yet.
  assign occupied = ~hiding | pending;
  assign eligible = hiding & ~pending;

  // Popcount of busy moles.
  always_comb begin
    up_count = '0;
    for (int i = 0; i < NUM_MOLES; i++) begin
      up_count = up_count + {3'd0, occupied[i]};
    end
  end

  assign at_cap      = int'(up_count) >= MAX_UP;
  assign gap_reached = tick && (gap_cnt >= GAP_LAST);

  // Next-state and next-output decode for the launch sequencer.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    state_next   = state;
    gap_next     = gap_cnt;
    idx_next     = idx;
    probe_next   = probe_cnt;
    pending_next = pending & hiding;  // drop pending once the mole has left its hole
    spawn_next   = spawn_cnt;
    control_next = '0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next   = WAIT_GAP;
          gap_next     = '0;
          pending_next = '0;
          spawn_next   = '0;
        end
      end

      WAIT_GAP: begin
        if (tick) begin
          if (!gap_reached) begin
            gap_next = gap_cnt + 4'd1;
          end else if (at_cap) begin
            gap_next = GAP_LAST;  // too many up: retry on the next tick
          end else begin
            gap_next   = '0;
            state_next = PICK;
            idx_next   = lfsr_value[IDX_W-1:0];
            probe_next = '0;
          end
        end
      end

      PICK: begin
        if (eligible[idx]) begin
          state_next         = LAUNCH;
          control_next[idx]  = 1'b1;
          pending_next[idx]  = 1'b1;
          spawn_next         = (spawn_cnt < 8'(ROUND_SPAWNS)) ? spawn_cnt + 8'd1 : spawn_cnt;
        end else if (probe_cnt == IDX_W'(NUM_MOLES - 1)) begin
          state_next = WAIT_GAP;
          gap_next   = GAP_LAST;
        end else begin
          idx_next   = idx + 1'b1;
          probe_next = probe_cnt + 1'b1;
        end
      end

      LAUNCH: begin
        // spawn_cnt was bumped on entry, so it already counts this launch.
        state_next = (spawn_cnt >= 8'(ROUND_SPAWNS)) ? DRAIN : WAIT_GAP;
      end

      DRAIN: begin
        if ((&hiding) && (pending == '0)) begin
          state_next = DONE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      idx         <= '0;
      probe_cnt   <= '0;
      pending     <= '0;
      spawn_cnt   <= '0;
      control     <= '0;
      game_active <= 1'b0;
      round_done  <= 1'b0;
    end else begin
      state       <= state_next;
      gap_cnt     <= gap_next;
      idx         <= idx_next;
      probe_cnt   <= probe_next;
      pending     <= pending_next;
      spawn_cnt   <= spawn_next;
      control     <= control_next;
      game_active <= (state_next == WAIT_GAP) || (state_next == PICK) ||
                     (state_next == LAUNCH)   || (state_next == DRAIN);
      round_done  <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// Scoreboard bench for mole_scheduler: directed rounds against a behavioural mole model.
`timescale 1ns/1ps
module tb_mole_scheduler;

  localparam int          MAX_UP       = 3;
  localparam int          ROUND_SPAWNS = 5;
  localparam int          GAP_TICKS    = 2;
  localparam logic [15:0] SEED         = 16'hACE1;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] hiding = 8'hFF;
  logic [7:0] control;
  logic       game_active;
  logic       round_done;
  logic [7:0] spawn_cnt;

  mole_scheduler #(
    .MAX_UP       (MAX_UP),
    .ROUND_SPAWNS (ROUND_SPAWNS),
    .GAP_TICKS    (GAP_TICKS),
    .LFSR_SEED    (SEED)
  ) dut (
    .CLOCK_50    (clk),
    .resetn      (resetn),
    .start       (start),
    .tick        (tick),
    .hiding      (hiding),
    .control     (control),
    .game_active (game_active),
    .round_done  (round_done),
    .spawn_cnt   (spawn_cnt)
  );

  always #5 clk = ~clk;

  // Rising-edge counter; at a falling edge it holds the number of the last rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] ctrl;
    logic [7:0] cnt;
    int         at;
  } launch_t;

  launch_t sb[$];
  int checks = 0;
  int errors = 0;

  // Mole model and bookkeeping, all owned by the stimulus process.
  logic [7:0] launch_req = '0;
  logic [7:0] pend_m = '0;
  int         up_left [8];
  bit         model_on = 0;
  bit         auto_ret = 0;
  int         up_len = 3;
  int         start_edge = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] v;
    v = SEED;
    for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    return v;
  endfunction

  // Each go pulse must match the oldest due launch in bits, count and cycle.
  task automatic monitor();
    launch_t e;
    forever begin
      @(negedge clk);
      if (resetn && control != 8'h00) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_go: control=0x%0h at cycle %0d, none due", control, cyc);
        end else begin
          e = sb.pop_front();
          check("go_bits", control, e.ctrl);
          check("go_spawn_cnt", spawn_cnt, e.cnt);
          check("go_cycle", cyc, e.at);
        end
      end
    end
  endtask

  // A mole leaves its hole one cycle after its go, stays up_len cycles, then returns.
  task automatic mole_update();
    if (model_on) begin
      for (int i = 0; i < 8; i++) begin
        if (launch_req[i]) begin
          hiding[i]     = 1'b0;
          launch_req[i] = 1'b0;
          up_left[i]    = up_len;
        end else if (!hiding[i] && auto_ret && up_left[i] > 0) begin
          up_left[i]--;
          if (up_left[i] == 0) hiding[i] = 1'b1;
        end
        if (control[i]) launch_req[i] = 1'b1;
      end
    end
    pend_m = pend_m & hiding;
  endtask

  // One clock: model update at the falling edge, then inputs for the next rising edge.
  task automatic cycle(input logic t = 1'b0, input logic s = 1'b0);
    @(negedge clk);
    mole_update();
    tick  = t;
    start = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    tick = 1'b0;
    start = 1'b0;
    hiding = 8'hFF;
    launch_req = '0;
    pend_m = '0;
    model_on = 0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic start_round();
    cycle(1'b0, 1'b1);
    start_edge = cyc + 1;
    cycle(1'b0, 1'b0);
  endtask

  task automatic gap_tick();
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
  endtask

  // Tick that reaches the gap; predict which mole is probed first and when it fires.
  task automatic tick_expect(input logic [7:0] elig, input logic [7:0] cnt_exp);
    launch_t     e;
    logic [15:0] v;
    int          base;
    int          j;
    bit          found;
    cycle(1'b1, 1'b0);
    v = lfsr_at(cyc - start_edge);
    base = int'(v[2:0]);
    found = 0;
    e.ctrl = '0;
    e.cnt = cnt_exp;
    e.at = 0;
    for (int k = 0; k < 8; k++) begin
      j = (base + k) % 8;
      if (!found && elig[j]) begin
        found = 1;
        e.ctrl[j] = 1'b1;
        e.at = cyc + 2 + k;
      end
    end
    if (found) begin
      sb.push_back(e);
      pend_m = pend_m | e.ctrl;
    end
    cycle(1'b0, 1'b0);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL launch_timeout: %0d launches still due after %0d cycles", sb.size(), budget);
      sb.delete();
    end
  endtask

  initial begin
    int bad;
    int n;
    int rel;
    fork
      monitor();
      begin
        #200us;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
      end
    join_none

    // Reset and idle.
    do_reset();
    bad = 0;
    repeat (100) begin
      cycle();
      if (control != 8'h00 || spawn_cnt != 8'h00 || game_active || round_done) bad++;
    end
    check("idle_active_cycles", bad, 0);
    check("idle_lfsr", dut.u_lfsr.value, 16'hACE1);

    // Single launch, then abuse: start mid-round, reset during LAUNCH.
    do_reset();
    model_on = 1;
    auto_ret = 1;
    up_len = 3;
    start_round();
    check("start_game_active", game_active, 1);
    check("start_spawn_cnt", spawn_cnt, 0);
    gap_tick();
    tick_expect(8'hFF, 8'd1);
    wait_drain(20);
    check("single_spawn_cnt", spawn_cnt, 1);
    cycle(1'b0, 1'b1);
    repeat (10) cycle();
    check("midround_start_cnt", spawn_cnt, 1);
    check("midround_start_active", game_active, 1);
    gap_tick();
    tick_expect(hiding & ~pend_m, 8'd2);
    n = 0;
    while (control == 8'h00 && n < 15) begin
      cycle();
      n++;
    end
    check("launch_seen_before_reset", (control != 8'h00), 1);
    #2 resetn = 1'b0;
    #1;
    check("reset_control", control, 0);
    check("reset_game_active", game_active, 0);
    check("reset_spawn_cnt", spawn_cnt, 0);

    // Occupancy cap: moles never return on their own.
    do_reset();
    model_on = 1;
    auto_ret = 0;
    start_round();
    for (int l = 1; l <= 3; l++) begin
      repeat (4) cycle();
      gap_tick();
      tick_expect(hiding & ~pend_m, 8'(l));
      wait_drain(20);
    end
    repeat (4) cycle();
    repeat (20) begin
      cycle(1'b1, 1'b0);
      cycle();
      cycle();
    end
    check("cap_spawn_cnt", spawn_cnt, 3);
    check("cap_game_active", game_active, 1);
    rel = 0;
    for (int i = 7; i >= 0; i--) if (!hiding[i]) rel = i;
    hiding[rel] = 1'b1;
    cycle();
    cycle();
    tick_expect(hiding & ~pend_m, 8'd4);
    wait_drain(20);
    check("cap_release_spawn_cnt", spawn_cnt, 4);

    // Probe wrap to the only free mole; tick during PICK must be dropped.
    do_reset();
    start_round();
    gap_tick();
    tick_expect(8'h80, 8'd1);
    hiding = 8'h80;
    cycle();
    cycle(1'b1, 1'b0);
    wait_drain(20);
    check("wrap_spawn_cnt", spawn_cnt, 1);
    // No mole free during probing: back to waiting, one tick retries.
    hiding = 8'hFF;
    repeat (3) cycle();
    gap_tick();
    tick_expect(8'h00, 8'd0);
    hiding = 8'h00;
    repeat (6) cycle();
    cycle(1'b1, 1'b0);
    cycle();
    cycle();
    hiding = 8'hFF;
    check("nofree_spawn_cnt", spawn_cnt, 1);
    check("nofree_game_active", game_active, 1);
    cycle();
    tick_expect(hiding & ~pend_m, 8'd2);
    wait_drain(20);
    check("retry_spawn_cnt", spawn_cnt, 2);

    // Full round with moles that come back, then drain, done and restart.
    do_reset();
    model_on = 1;
    auto_ret = 1;
    up_len = 3;
    start_round();
    for (int l = 1; l <= ROUND_SPAWNS; l++) begin
      repeat (10) cycle();
      gap_tick();
      tick_expect(hiding & ~pend_m, 8'(l));
      wait_drain(20);
    end
    check("drain_round_done", round_done, 0);
    check("drain_game_active", game_active, 1);
    n = 0;
    while (!round_done && n < 40) begin
      cycle();
      n++;
    end
    check("round_done", round_done, 1);
    check("done_spawn_cnt", spawn_cnt, ROUND_SPAWNS);
    check("done_game_active", game_active, 0);
    repeat (3) gap_tick();
    check("done_hold_spawn_cnt", spawn_cnt, ROUND_SPAWNS);
    cycle(1'b0, 1'b1);
    cycle();
    check("restart_spawn_cnt", spawn_cnt, 0);
    check("restart_game_active", game_active, 1);
    check("restart_round_done", round_done, 0);

    repeat (5) cycle();
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Sequencer that decides when and which of the eight rise/lower mole units receives its one-cycle `go` request. It runs one game round of a fixed number of launches: it paces launches from a tick input, chooses moles pseudo-randomly from an LFSR, and caps how many moles are above ground at once. It sits between the top-level game control and the per-mole `control[7:0]` bus feeding the mole/score/rise counter datapath, using the per-mole `hiding` flags as its status feedback.

## Interface
- `NUM_MOLES`, 8: number of mole units; fixed at 8, with a 3-bit index.
- `MAX_UP`, 3: maximum moles simultaneously out of hiding (1..8).
- `ROUND_SPAWNS`, 60: launches per round (1..255).
- `GAP_TICKS`, 2: `tick` pulses between consecutive launch attempts (1..15).
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- `CLOCK_50`  in  1  sole clock; all state is on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a round; honoured only in IDLE or DONE.
- `tick`  in  1  one-cycle pacing strobe synchronous to `CLOCK_50`.
- `hiding`  in  8  per-mole flag; 1 means the mole is fully down and idle.
- `control`  out  8  one-hot `go` pulse to the chosen mole, one cycle wide.
- `game_active`  out  1  high from WAIT_GAP through DRAIN.
- `round_done`  out  1  high while in DONE.
- `spawn_cnt`  out  8  number of launches issued this round.

## Operation
- `pending[7:0]` register:
  - Set bit i when `control[i]` is issued.
  - Clear bit i on the first cycle `hiding[i]`=0 after launch. This covers the one-cycle latency of the mole FSM.
- Eligibility and occupancy:
  - Mole i is eligible when `hiding[i]`=1 and `pending[i]`=0.
  - `up_count` = popcount(~hiding | pending), computed combinationally.
- LFSR:
  - 16-bit Galois, taps 16,14,13,11.
  - Advances every cycle outside IDLE; holds its value in IDLE and DONE.
- States:
  - IDLE: outputs low. On `start`, clear `spawn_cnt`, `pending` and the gap counter, then go to WAIT_GAP.
  - WAIT_GAP:
    - Each `tick` increments `gap_cnt`.
    - When `gap_cnt` reaches `GAP_TICKS`, clear it and go to PICK. If `up_count` ≥ `MAX_UP` at that moment, stay in WAIT_GAP and retry on the next tick.
  - PICK:
    - Load `idx` = lfsr[2:0] on entry.
    - Each cycle: if mole `idx` is eligible, go to LAUNCH; otherwise `idx` = `idx`+1 mod 8.
    - After 8 probes with no eligible mole, return to WAIT_GAP with `gap_cnt`=GAP_TICKS-1, so the next tick retries.
  - LAUNCH (one cycle):
    - Assert `control[idx]`, set `pending[idx]`, increment `spawn_cnt`.
    - If `spawn_cnt`+1 == `ROUND_SPAWNS`, go to DRAIN; otherwise go to WAIT_GAP.
  - DRAIN: wait until `hiding`==8'hFF and `pending`==0, then go to DONE.
  - DONE: hold `round_done`=1 and `spawn_cnt`. On `start`, begin a new round exactly as from IDLE.
- Boundary rules:
  - `start` during WAIT_GAP, PICK, LAUNCH or DRAIN is ignored.
  - `tick` during PICK, LAUNCH or DRAIN is dropped, not queued.
  - `tick` and the PICK-exit happening in the same cycle: the tick is not counted.
  - `spawn_cnt` never wraps; it saturates at `ROUND_SPAWNS`.
  - A mole that leaves hiding without a launch counts in `up_count` but is never pending.

## Timing
- Reset values:
  - `control`=0, `game_active`=0, `round_done`=0, `spawn_cnt`=0.
  - State=IDLE, `pending`=0, `gap_cnt`=0, lfsr=`LFSR_SEED`.
- All outputs are registered.
- `start` to `game_active`=1: 1 cycle.
- Tick reaching `GAP_TICKS` to `control` pulse: 2 to 9 cycles. This is 1 cycle to PICK, 0 to 7 probe cycles, and 1 cycle in LAUNCH.
- `control` is high for exactly 1 cycle. Never more than one bit is set.
- Asserting `resetn` mid-round clears all state immediately. Any in-flight `control` pulse is truncated. Moles that are already up finish their own cycle unaffected.

## Structure
- Shared package `mole_pkg` holds:
  - the state encoding localparams (IDLE, WAIT_GAP, PICK, LAUNCH, DRAIN, DONE);
  - the LFSR tap mask;
  - `NUM_MOLES`.
- Sub-module `mole_lfsr16` (clock, resetn, enable, seed, value), reusable by a later random-height block.
- The popcount and eligibility logic stay inline in `mole_scheduler`.

## Test plan
- Reset and idle: hold `resetn`=0 then release with `hiding`=FF and no `start`. Required: `control`=0 and `spawn_cnt`=0 for 100 cycles, with lfsr stable at ACE1.
- Single launch: `start`, `GAP_TICKS`=2, then tick twice with `hiding`=FF. Required: exactly one `control` bit pulses for 1 cycle, at the bit chosen by lfsr[2:0], and `spawn_cnt`=1.
- Occupancy cap: the mole model never returns to hiding, with `MAX_UP`=3. Required: after 3 launches, no further `control` pulse across 20 ticks; releasing one mole allows the 4th launch.
- Probe wrap: `hiding`=8'b1000_0000 only, LFSR index 0. Required: `control`=8'h80 after 7 probe cycles. With `hiding`=00 there is no pulse and the FSM is back in WAIT_GAP.
- Full round: `ROUND_SPAWNS`=5 with a behavioural mole model. Required: `spawn_cnt`=5, then DRAIN, then `round_done`=1 once `hiding`=FF. A second `start` restarts from `spawn_cnt`=0.
- Abuse: `start` pulsed mid-round is ignored; `resetn` dropped in the LAUNCH cycle gives `control`=0 at once and `game_active`=0.
